write_back_ctrl: RTL and testbench

- Registered, parametrised write-back stage for the recursive-search accelerator.
- Sits after the execute stage and accepts one result per handshake.
- Converts the execute stage's termination, position-update and new-call flags into two write streams:
  - a masked random-access write to the state memory at the current call's address;
  - a push of a new frame (InexRecur word plus initial state word) at an internally tracked stack pointer.
- Adds stack-overflow detection and termination-cause reporting.

---
 rtl/wb_pkg.sv | 12 +
 rtl/wb_stack_ptr.sv | 32 +++
 rtl/write_back_ctrl.sv | 124 ++++++++++++
 tb/tb_write_back_ctrl.sv | 131 +++++++++++++
 4 files changed

// File: rtl/wb_pkg.sv
// wb_pkg: shared state-word field offsets, mask bit indices and termination-cause codes.
package wb_pkg;
  localparam int DONE_BIT = 0;
  localparam int PARENT_LSB = 1;
  localparam int MASK_DONE = 0;
  localparam int MASK_PARENT = 1;
  localparam int MASK_POS = 2;
  localparam logic [1:0] TC_NONE = 2'd0;
  localparam logic [1:0] TC_Z = 2'd1;
  localparam logic [1:0] TC_I = 2'd2;
  localparam logic [1:0] TC_DONE = 2'd3;
endpackage

// File: rtl/wb_stack_ptr.sv
// wb_stack_ptr: frame stack pointer with synchronous clear, full detection and sticky overflow.
module wb_stack_ptr #(
  parameter int ADDR_W = 12,
  parameter int STACK_DEPTH = 4096,
  parameter int SP_INIT = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              inc,
  input  logic              ovf_set,
  output logic [ADDR_W:0]   sp,
  output logic              full,
  output logic              ovf
);
  logic [ADDR_W:0] sp_q, sp_d;
  logic ovf_q;
  // clear takes priority over a same-cycle push increment
  assign sp_d = clr ? (ADDR_W+1)'(SP_INIT) : inc ? sp_q + (ADDR_W+1)'(1) : sp_q;
  assign sp = sp_q;
  assign full = sp_q >= (ADDR_W+1)'(STACK_DEPTH);
  assign ovf = ovf_q;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sp_q <= (ADDR_W+1)'(SP_INIT);
      ovf_q <= 1'b0;
    end else begin
      sp_q <= sp_d;
      ovf_q <= ovf_q | ovf_set;
    end
  end
endmodule

// File: rtl/write_back_ctrl.sv
// write_back_ctrl: registered write-back stage producing masked state writes and frame pushes.
// Optional counters stat_calls/stat_terms/stat_drops under WRITE_BACK_CTRL_STATS_EN.
module write_back_ctrl
  import wb_pkg::*;
#(
  parameter int ADDR_W = 12,
  parameter int VAL_W = 8,
  parameter int POS_W = 5,
  parameter int STACK_DEPTH = 4096,
  parameter int SP_INIT = 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      sp_clr,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [ADDR_W-1:0]         cur_addr,
  input  logic                      over_1,
  input  logic                      over_2,
  input  logic                      over_3,
  input  logic                      en_new_pos,
  input  logic [POS_W-1:0]          new_pos,
  input  logic                      new_call,
  input  logic [VAL_W-1:0]          i_new,
  input  logic [VAL_W-1:0]          z_new,
  input  logic [VAL_W-1:0]          k_new,
  input  logic [VAL_W-1:0]          l_new,
  output logic                      st_we,
  output logic [ADDR_W-1:0]         st_addr,
  output logic [POS_W+ADDR_W:0]     st_data,
  output logic [2:0]                st_mask,
  output logic                      push_we,
  output logic [ADDR_W-1:0]         push_addr,
  output logic [4*VAL_W-1:0]        push_rec,
  output logic [POS_W+ADDR_W:0]     push_state,
  output logic [ADDR_W:0]           sp,
  output logic [1:0]                term_cause,
  output logic                      ovf
`ifdef WRITE_BACK_CTRL_STATS_EN
  ,
  output logic [31:0]               stat_calls,
  output logic [31:0]               stat_terms,
  output logic [15:0]               stat_drops
`endif
);
  typedef enum logic {IDLE, WRITE} state_t;
  state_t state_q;
  logic st_we_q, push_we_q, full, accept, any_over, ovf_set, push_inc;
  logic [ADDR_W-1:0] st_addr_q, push_addr_q;
  logic [POS_W+ADDR_W:0] st_data_q, push_state_q;
  logic [2:0] st_mask_q;
  logic [4*VAL_W-1:0] push_rec_q;
  logic [1:0] term_cause_q;
  assign accept = state_q == IDLE && in_valid;
  assign any_over = over_1 | over_2 | over_3;
  assign ovf_set = accept && new_call && full;
  assign push_inc = state_q == WRITE && push_we_q;
  assign in_ready = state_q == IDLE;
  assign st_we = st_we_q;
  assign st_addr = st_addr_q;
  assign st_data = st_data_q;
  assign st_mask = st_mask_q;
  assign push_we = push_we_q;
  assign push_addr = push_addr_q;
  assign push_rec = push_rec_q;
  assign push_state = push_state_q;
  assign term_cause = term_cause_q;
  wb_stack_ptr #(.ADDR_W(ADDR_W), .STACK_DEPTH(STACK_DEPTH), .SP_INIT(SP_INIT)) u_sp (
    .clk(clk), .rst_n(rst_n), .clr(sp_clr), .inc(push_inc), .ovf_set(ovf_set),
    .sp(sp), .full(full), .ovf(ovf)
  );
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      st_we_q <= 1'b0;
      st_addr_q <= '0;
      st_data_q <= '0;
      st_mask_q <= '0;
      push_we_q <= 1'b0;
      push_addr_q <= '0;
      push_rec_q <= '0;
      push_state_q <= '0;
      term_cause_q <= TC_NONE;
    end else if (accept) begin
      state_q <= WRITE;
      st_we_q <= any_over | en_new_pos;
      st_addr_q <= cur_addr;
      st_data_q <= '0;
      st_data_q[DONE_BIT] <= any_over;
      st_data_q[ADDR_W+1 +: POS_W] <= en_new_pos ? new_pos : '0;
      st_mask_q[MASK_DONE] <= any_over;
      st_mask_q[MASK_PARENT] <= 1'b0;
      st_mask_q[MASK_POS] <= en_new_pos;
      push_we_q <= new_call && !full;
      push_addr_q <= sp[ADDR_W-1:0];
      push_rec_q <= {i_new, z_new, k_new, l_new};
      push_state_q <= '0;
      push_state_q[PARENT_LSB +: ADDR_W] <= cur_addr;
      if (any_over) term_cause_q <= over_1 ? TC_Z : over_2 ? TC_I : TC_DONE;
    end else begin
      state_q <= IDLE;
      st_we_q <= 1'b0;
      push_we_q <= 1'b0;
    end
  end
`ifdef WRITE_BACK_CTRL_STATS_EN
  logic [31:0] calls_q, terms_q;
  logic [15:0] drops_q;
  assign stat_calls = calls_q;
  assign stat_terms = terms_q;
  assign stat_drops = drops_q;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      calls_q <= '0;
      terms_q <= '0;
      drops_q <= '0;
    end else begin
      if (push_inc && calls_q != '1) calls_q <= calls_q + 32'd1;
      if (state_q == WRITE && st_mask_q[MASK_DONE] && terms_q != '1) terms_q <= terms_q + 32'd1;
      if (ovf_set && drops_q != '1) drops_q <= drops_q + 16'd1;
    end
  end
`endif
endmodule

// File: tb/tb_write_back_ctrl.sv
// tb_write_back_ctrl: directed and random transactions checked against a rule-level model.
module tb_write_back_ctrl;
  localparam int DEPTH = 4;
  logic clk = 1'b0, rst_n = 1'b0, sp_clr = 1'b0, in_valid = 1'b0, in_ready;
  logic [11:0] cur_addr = '0;
  logic over_1 = 0, over_2 = 0, over_3 = 0, en_new_pos = 0, new_call = 0;
  logic [4:0] new_pos = '0;
  logic [7:0] i_new = '0, z_new = '0, k_new = '0, l_new = '0;
  logic st_we, push_we, ovf;
  logic [11:0] st_addr, push_addr;
  logic [17:0] st_data, push_state;
  logic [2:0] st_mask;
  logic [31:0] push_rec;
  logic [12:0] sp;
  logic [1:0] term_cause;
  int checks = 0, errors = 0;
  int msp = 1;
  logic movf = 0;
  logic [1:0] mtc = 0;

  write_back_ctrl #(.STACK_DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .sp_clr(sp_clr), .in_valid(in_valid), .in_ready(in_ready),
    .cur_addr(cur_addr), .over_1(over_1), .over_2(over_2), .over_3(over_3),
    .en_new_pos(en_new_pos), .new_pos(new_pos), .new_call(new_call),
    .i_new(i_new), .z_new(z_new), .k_new(k_new), .l_new(l_new),
    .st_we(st_we), .st_addr(st_addr), .st_data(st_data), .st_mask(st_mask),
    .push_we(push_we), .push_addr(push_addr), .push_rec(push_rec), .push_state(push_state),
    .sp(sp), .term_cause(term_cause), .ovf(ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic txn(input logic [11:0] a, input logic o1, input logic o2, input logic o3,
                     input logic ep, input logic [4:0] p, input logic nc,
                     input logic [31:0] rec, input logic clr);
    logic any, psh;
    @(negedge clk);
    in_valid = 1; cur_addr = a; over_1 = o1; over_2 = o2; over_3 = o3;
    en_new_pos = ep; new_pos = p; new_call = nc; {i_new, z_new, k_new, l_new} = rec;
    any = o1 | o2 | o3;
    psh = nc && msp < DEPTH;
    if (nc && !psh) movf = 1;
    if (o1) mtc = 1; else if (o2) mtc = 2; else if (o3) mtc = 3;
    @(posedge clk); #1;
    chk("in_ready_busy", in_ready, 0);
    chk("st_we", st_we, any | ep);
    if (any | ep) begin
      chk("st_addr", st_addr, a);
      chk("st_data", st_data, {ep ? p : 5'd0, 12'd0, any});
      chk("st_mask", st_mask, {ep, 1'b0, any});
    end
    chk("push_we", push_we, psh);
    if (psh) begin
      chk("push_addr", push_addr, msp);
      chk("push_rec", push_rec, rec);
      chk("push_state", push_state, {5'd0, a, 1'b0});
    end
    chk("term_cause", term_cause, mtc);
    chk("ovf", ovf, movf);
    @(negedge clk);
    in_valid = 0; sp_clr = clr;
    if (clr) msp = 1; else if (psh) msp++;
    @(posedge clk); #1;
    sp_clr = 0;
    chk("sp", sp, msp);
    chk("in_ready_idle", in_ready, 1);
    chk("st_we_idle", st_we, 0);
    chk("push_we_idle", push_we, 0);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_st_we", st_we, 0);
    chk("rst_push_we", push_we, 0);
    chk("rst_sp", sp, 1);
    chk("rst_tc", term_cause, 0);
    chk("rst_ovf", ovf, 0);
    chk("rst_ready", in_ready, 1);
    chk("rst_st_data", st_data, 0);
    chk("rst_mask", st_mask, 0);
    @(negedge clk); rst_n = 1;
    txn(12'h005, 0, 0, 0, 0, 5'd0, 1, 32'h03020709, 0);
    txn(12'h010, 0, 1, 0, 1, 5'h0C, 0, 32'h0, 0);
    txn(12'h020, 1, 0, 1, 0, 5'h00, 0, 32'h0, 0);
    txn(12'h030, 0, 0, 0, 0, 5'h00, 0, 32'h0, 0);
    txn(12'h040, 0, 0, 0, 0, 5'h00, 1, 32'h11223344, 0);
    txn(12'h041, 0, 0, 0, 0, 5'h00, 1, 32'h55667788, 0);
    txn(12'h042, 0, 0, 1, 0, 5'h00, 1, 32'h99AABBCC, 0);
    chk("full_sp", sp, DEPTH);
    chk("full_ovf", ovf, 1);
    txn(12'h050, 0, 0, 0, 0, 5'h00, 0, 32'h0, 1);
    txn(12'h051, 0, 0, 0, 0, 5'h00, 1, 32'hDEADBEEF, 0);
    txn(12'h052, 0, 0, 0, 0, 5'h00, 1, 32'hCAFEF00D, 1);
    for (int n = 0; n < 300; n++)
      txn(12'($urandom), $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0,
          $urandom_range(0, 3) == 0, $urandom_range(0, 1) == 1, 5'($urandom),
          $urandom_range(0, 1) == 1, $urandom, $urandom_range(0, 9) == 0);
    txn(12'h060, 0, 0, 0, 0, 5'h00, 0, 32'h0, 1);
    txn(12'h061, 0, 0, 0, 0, 5'h00, 1, 32'h01020304, 0);
    @(negedge clk);
    in_valid = 1; cur_addr = 12'h070; new_call = 1; over_3 = 1;
    {over_1, over_2, en_new_pos} = '0;
    @(posedge clk); #1;
    chk("pre_rst_push_we", push_we, 1);
    chk("pre_rst_st_we", st_we, 1);
    chk("pre_rst_ovf", ovf, 1);
    @(negedge clk);
    in_valid = 0; rst_n = 0;
    @(posedge clk); #1;
    chk("wrst_st_we", st_we, 0);
    chk("wrst_push_we", push_we, 0);
    chk("wrst_sp", sp, 1);
    chk("wrst_ovf", ovf, 0);
    chk("wrst_tc", term_cause, 0);
    @(negedge clk); rst_n = 1;
    @(posedge clk); #1;
    chk("wrst_ready", in_ready, 1);
    chk("wrst_sp_hold", sp, 1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
